sar_avg_fifo: RTL and testbench
===============================

// Module: sar_avg_fifo
// PURPOSE
//  Downstream consumer of the SAR conversion controller. Takes each finished 8-bit
//  SAR code (SAROut plus a one-cycle done strobe) and averages 2**LOG2_AVG
//  consecutive codes with round-half-up. Buffers the averages in a small FIFO with
//  a valid/ready output handshake, so the system bus can drain results at its own pace.
// PARAMETERS
//  DATA_W      8  width of SAR code and of averaged result
//  LOG2_AVG    2  log2 of samples per average (0 = pass-through, no averaging)
//  FIFO_DEPTH  4  result FIFO entries; power of two, >= 2
// PORTS
//  Clock        in   1                       single clock, all logic on rising edge
//  Reset        in   1                       synchronous, active-high
//  SARIn        in   DATA_W                  finished SAR code (SAROut of SAR stage)
//  SARValid     in   1                       one-cycle strobe: SARIn is final this cycle
//  Clear        in   1                       restart accumulation, clear Overflow
//  OutReady     in   1                       consumer accepts OutData this cycle
//  OutData      out  DATA_W                  head of FIFO (oldest average)
//  OutValid     out  1                       FIFO non-empty
//  Level        out  $clog2(FIFO_DEPTH)+1    FIFO occupancy, 0..FIFO_DEPTH
//  Overflow     out  1                       sticky: an average was dropped (FIFO full)
// BEHAVIOUR
//  Reset (sync, one cycle): accumulator=0, sample count=0, FIFO empty, OutData=0,
//   OutValid=0, Level=0, Overflow=0. Reset mid-accumulation discards partial sum.
//  Accumulate: accumulator is DATA_W+LOG2_AVG bits; count is LOG2_AVG bits.
//   - SARValid & ~Clear & count < N-1 (N=2**LOG2_AVG): acc += SARIn, count++.
//   - SARValid & ~Clear & count == N-1: avg = (acc + SARIn + (N>>1)) >> LOG2_AVG.
//     avg is pushed into the FIFO on this same edge. acc and count go to 0.
//     No saturation needed: max sum is N*(2**DATA_W-1)+N/2 < N*2**DATA_W.
//     Intermediate sum is carried at DATA_W+LOG2_AVG+1 bits.
//   - LOG2_AVG=0: every SARValid pushes SARIn unchanged.
//  Clear: acc=0, count=0, Overflow=0. Clear wins over a same-cycle SARValid, whose
//   sample is discarded. FIFO contents are kept.
//  Latency: OutValid rises the cycle after the edge that completes the Nth sample
//   (FIFO empty case). Until then OutData holds its last value.
//  FIFO: registered storage, first-word fall-through. OutData = oldest entry
//   whenever OutValid=1.
//   - Pop when OutValid & OutReady. OutReady with OutValid=0 is ignored.
//   - Push is accepted if Level<FIFO_DEPTH, or if Level==FIFO_DEPTH and a pop occurs
//     in the same cycle. Level is unchanged on a simultaneous push+pop.
//   - Push while full with no pop: the average is dropped, Overflow<=1 (sticky until
//     Clear/Reset), and the accumulator still restarts.
//  Pointers wrap modulo FIFO_DEPTH. Level is the explicit count, not a pointer diff.
//  SARIn is sampled only when SARValid=1. Back-to-back SARValid every cycle is legal.
// TESTING (LOG2_AVG=2, FIFO_DEPTH=4 unless noted)
//  1. Reset, then SARValid with 10,11,12,13, OutReady=1 -> one cycle after 4th strobe:
//     OutValid=1 and OutData=12 for one cycle, then OutValid=0 and Level=0.
//  2. Rounding: 0,0,0,2 -> OutData=1. 0,0,0,1 -> OutData=0.
//     4x255 -> OutData=255, no wrap.
//  3. OutReady=0, five averages (values 1..5) -> Level=4, Overflow=1.
//     Then OutReady=1 drains 1,2,3,4 in order, and average 5 is never output.
//  4. FIFO full and OutReady=1 in the cycle the 4th sample completes avg=9 -> pop and
//     push both occur. Level stays 4, Overflow stays 0, and 9 is the last entry drained.
//  5. Two samples (100,100), then Clear with SARValid(200) in the same cycle, then
//     20,20,20,20 -> single output 20. The 200 sample is discarded and Overflow is 0.
//  6. Reset asserted mid-accumulation with 2 entries queued -> next cycle OutValid=0,
//     Level=0, OutData=0. A fresh 4 samples (8,8,8,8) then yields 8.
//     Repeat test 1 with LOG2_AVG=0: each SARValid code appears unchanged one cycle later.

Source files
------------

// File: rtl/sar_avg_fifo.sv
// rtl/sar_avg_fifo.sv - averages 2**LOG2_AVG finished SAR codes with round-half-up into a small result FIFO
// First-word fall-through FIFO with a registered head word; a dropped average sets a sticky overflow flag.
module sar_avg_fifo #(
    parameter int DATA_W     = 8,
    parameter int LOG2_AVG   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_W-1:0]               sar_in,
    input  logic                            sar_valid,
    input  logic                            clear,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_valid,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            overflow
);
    localparam int N  = 1 << LOG2_AVG;
    localparam int AW = DATA_W + LOG2_AVG;
    localparam int SW = AW + 1;
    localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [AW-1:0]     acc;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     sum;
    logic [SW-1:0]     sum_sh;
    logic              sum_unused;
    logic [DATA_W-1:0] avg;
    logic              last;
    logic              push;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic              drop;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_n;
    logic [LW-1:0]     level_n;
    logic [LW-1:0]     remain;
    logic [DATA_W-1:0] head_n;

    // Sum carries one guard bit so the rounding constant can never wrap.
    assign sum        = {1'b0, acc} + SW'(sar_in) + SW'(N >> 1);
    assign sum_sh     = sum >> LOG2_AVG;
    assign avg        = sum_sh[DATA_W-1:0];
    assign sum_unused = ^sum_sh;

    assign last    = (cnt == CW'(N - 1));
    assign push    = sar_valid & ~clear & last;
    assign pop     = out_valid & out_ready;
    assign full    = (level == LW'(FIFO_DEPTH));
    assign push_ok = push & (~full | pop);
    assign drop    = push & ~push_ok;

    assign level_n  = level + LW'(push_ok) - LW'(pop);
    assign rd_ptr_n = rd_ptr + PW'(pop);
    assign remain   = level - LW'(pop);
    // When nothing older survives the pop, the incoming average becomes the head directly.
    assign head_n   = (remain == '0) ? avg : mem[rd_ptr_n];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= avg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (sar_valid) begin
                if (last) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= acc + AW'(sar_in);
                    cnt <= cnt + CW'(1);
                end
            end

            if (clear) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr    <= rd_ptr_n;
            level     <= level_n;
            out_valid <= (level_n != '0);
            if (level_n != '0) begin
                out_data <= head_n;
            end
        end
    end

endmodule

// File: tb/tb_sar_avg_fifo.sv
// tb/tb_sar_avg_fifo.sv - directed bench for sar_avg_fifo with a queue-based reference model
module tb_sar_avg_fifo;
    localparam int NAVG  = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sar_in = '0;
    logic       sar_valid = 1'b0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b0;

    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] level;
    logic       overflow;

    logic [7:0] o0_data;
    logic       o0_valid;
    logic [2:0] o0_level;
    logic       o0_overflow;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    int mq[$];
    int macc, mcnt, mavg, mlast;
    bit movf, do_pop, do_push;

    always #5 clk = ~clk;

    sar_avg_fifo #(.DATA_W(8), .LOG2_AVG(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .sar_in(sar_in), .sar_valid(sar_valid),
        .clear(clear), .out_ready(out_ready), .out_data(out_data),
        .out_valid(out_valid), .level(level), .overflow(overflow)
    );

    sar_avg_fifo #(.DATA_W(8), .LOG2_AVG(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .reset(reset), .sar_in(sar_in), .sar_valid(sar_valid),
        .clear(clear), .out_ready(out_ready), .out_data(o0_data),
        .out_valid(o0_valid), .level(o0_level), .overflow(o0_overflow)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: averages are plain integer arithmetic, the FIFO is a queue.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            macc = 0; mcnt = 0; movf = 0; mlast = 0;
        end else begin
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = 0;
            if (clear) begin
                macc = 0; mcnt = 0; movf = 0;
            end else if (sar_valid) begin
                if (mcnt == NAVG - 1) begin
                    mavg = (macc + int'(sar_in) + NAVG / 2) / NAVG;
                    do_push = 1;
                    macc = 0; mcnt = 0;
                end else begin
                    macc += int'(sar_in);
                    mcnt++;
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < DEPTH) mq.push_back(mavg);
                else movf = 1;
            end
            if (mq.size() > 0) mlast = mq[0];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_valid", 32'(out_valid), 32'(mq.size() > 0));
            check("model_level", 32'(level), 32'(mq.size()));
            check("model_overflow", 32'(overflow), 32'(movf));
            check("model_data", 32'(out_data), 32'(mlast));
        end
    end

    task automatic cyc(input bit v, input int d, input bit clr, input bit rdy);
        sar_valid = v;
        sar_in    = 8'(d);
        clear     = clr;
        out_ready = rdy;
        @(posedge clk);
        #1;
        sar_valid = 0;
        clear     = 0;
    endtask

    task automatic avg4(input int a, input int b, input int c, input int d, input bit rdy);
        cyc(1, a, 0, rdy);
        cyc(1, b, 0, rdy);
        cyc(1, c, 0, rdy);
        cyc(1, d, 0, rdy);
    endtask

    initial begin
        reset = 1;
        cyc(0, 0, 0, 0);
        reset = 0;
        chk_en = 1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_overflow", 32'(overflow), 0);

        avg4(10, 11, 12, 13, 1);
        check("t1_valid", 32'(out_valid), 1);
        check("t1_data", 32'(out_data), 12);
        cyc(0, 0, 0, 1);
        check("t1_valid_after", 32'(out_valid), 0);
        check("t1_level_after", 32'(level), 0);

        avg4(0, 0, 0, 2, 1);
        check("t2_half_up", 32'(out_data), 1);
        cyc(0, 0, 0, 1);
        avg4(0, 0, 0, 1, 1);
        check("t2_below_half", 32'(out_data), 0);
        cyc(0, 0, 0, 1);
        avg4(255, 255, 255, 255, 1);
        check("t2_max", 32'(out_data), 255);
        cyc(0, 0, 0, 1);

        for (int v = 1; v <= 5; v++) avg4(v, v, v, v, 0);
        check("t3_level", 32'(level), 4);
        check("t3_overflow", 32'(overflow), 1);
        for (int v = 1; v <= 4; v++) begin
            check("t3_drain_valid", 32'(out_valid), 1);
            check("t3_drain_data", 32'(out_data), 32'(v));
            cyc(0, 0, 0, 1);
        end
        check("t3_empty", 32'(out_valid), 0);
        check("t3_overflow_kept", 32'(overflow), 1);
        cyc(0, 0, 1, 1);
        check("t3_overflow_cleared", 32'(overflow), 0);

        for (int v = 1; v <= 4; v++) avg4(v, v, v, v, 0);
        cyc(1, 9, 0, 0);
        cyc(1, 9, 0, 0);
        cyc(1, 9, 0, 0);
        cyc(1, 9, 0, 1);
        check("t4_level", 32'(level), 4);
        check("t4_overflow", 32'(overflow), 0);
        check("t4_head", 32'(out_data), 2);
        for (int i = 0; i < 4; i++) begin
            int exp4 [4] = '{2, 3, 4, 9};
            check("t4_drain_data", 32'(out_data), 32'(exp4[i]));
            cyc(0, 0, 0, 1);
        end
        check("t4_empty", 32'(out_valid), 0);

        cyc(1, 100, 0, 1);
        cyc(1, 100, 0, 1);
        cyc(1, 200, 1, 1);
        avg4(20, 20, 20, 20, 1);
        check("t5_data", 32'(out_data), 20);
        check("t5_overflow", 32'(overflow), 0);
        cyc(0, 0, 0, 1);
        check("t5_single", 32'(out_valid), 0);

        avg4(5, 5, 5, 5, 0);
        avg4(6, 6, 6, 6, 0);
        check("t6_level_before", 32'(level), 2);
        cyc(1, 7, 0, 0);
        cyc(1, 7, 0, 0);
        reset = 1;
        cyc(0, 0, 0, 0);
        reset = 0;
        check("t6_valid", 32'(out_valid), 0);
        check("t6_level", 32'(level), 0);
        check("t6_data", 32'(out_data), 0);
        avg4(8, 8, 8, 8, 1);
        check("t6_fresh_valid", 32'(out_valid), 1);
        check("t6_fresh_data", 32'(out_data), 8);
        cyc(0, 0, 0, 1);

        reset = 1;
        cyc(0, 0, 0, 0);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            int codes [3] = '{3, 200, 77};
            cyc(1, codes[i], 0, 1);
            check("t7_pass_valid", 32'(o0_valid), 1);
            check("t7_pass_data", 32'(o0_data), 32'(codes[i]));
        end
        cyc(0, 0, 0, 1);
        check("t7_empty", 32'(o0_valid), 0);
        check("t7_level", 32'(o0_level), 0);
        check("t7_overflow", 32'(o0_overflow), 0);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
